// File: rtl/step_logger_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper for the step/dir position logger.
package step_logger_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SNAP = 3'd1,
    ST_HEX  = 3'd2,
    ST_SEP  = 3'd3,
    ST_EOL  = 3'd4
  } state_e;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = ASCII_0 + {4'h0, nib};
    end else begin
      res = ASCII_A + ({4'h0, nib} - 8'd10);
    end
    return res;
  endfunction

endpackage

// File: rtl/step_axis_counter.sv
// One step/dir channel: 2-FF synchronisers, registered rising-edge detect, and a
// wrapping up/down position counter with synchronous clear taking priority.
module step_axis_counter #(
  parameter int W = 16
) (
  input  logic         hwclk,
  input  logic         rst,
  input  logic         step,
  input  logic         dir,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic         step_sync1_r;
  logic         step_sync2_r;
  logic         step_prev_r;
  logic         dir_sync1_r;
  logic         dir_sync2_r;
  logic         edge_r;
  logic         edge_dir_r;
  logic [W-1:0] count_r;

  // Dir is captured alongside the edge so both come from the same sync stage.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      step_sync1_r <= 1'b0;
      step_sync2_r <= 1'b0;
      step_prev_r  <= 1'b0;
      dir_sync1_r  <= 1'b0;
      dir_sync2_r  <= 1'b0;
      edge_r       <= 1'b0;
      edge_dir_r   <= 1'b0;
    end else begin
      step_sync1_r <= step;
      step_sync2_r <= step_sync1_r;
      step_prev_r  <= step_sync2_r;
      dir_sync1_r  <= dir;
      dir_sync2_r  <= dir_sync1_r;
      edge_r       <= step_sync2_r & ~step_prev_r;
      edge_dir_r   <= dir_sync2_r;
    end
  end

  // Position counter; wraps modulo 2^W in both directions.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (edge_r) begin
      if (edge_dir_r) begin
        count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/step_logger_hex.sv
// N-axis step/dir position logger: snapshots all axis counters and serialises them
// as an ASCII-hex frame "XXXX,YYYY,...\n" over a valid/ready byte stream.
module step_logger_hex #(
  parameter int         N_AXES   = 4,
  parameter int         NIBBLES  = 4,
  parameter logic [7:0] SEP_CHAR = 8'h2C
) (
  input  logic              hwclk,
  input  logic              rst,
  input  logic [N_AXES-1:0] step,
  input  logic [N_AXES-1:0] dir,
  input  logic              clear,
  input  logic              report_en,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_done,
  output logic              busy
);

  import step_logger_pkg::*;

  localparam int         W         = 4 * NIBBLES;
  localparam int         TOT       = N_AXES * W;
  localparam logic [2:0] LAST_NIB  = 3'(NIBBLES - 1);
  localparam logic [2:0] LAST_AXIS = 3'(N_AXES - 1);

  logic [TOT-1:0] snapshot_s;

  // Axis 0 lands in the most significant slice so the frame shifts out MSB-first.
  genvar g;
  generate
    for (g = 0; g < N_AXES; g++) begin : g_axis
      logic [W-1:0] count_s;
      step_axis_counter #(.W(W)) u_counter (
        .hwclk (hwclk),
        .rst   (rst),
        .step  (step[g]),
        .dir   (dir[g]),
        .clear (clear),
        .count (count_s)
      );
      assign snapshot_s[TOT-1-g*W -: W] = count_s;
    end
  endgenerate

  state_e         state_r,      state_s;
  logic [TOT-1:0] shift_r,      shift_s;
  logic [2:0]     nib_r,        nib_s;
  logic [2:0]     axis_r,       axis_s;
  logic [7:0]     tx_byte_r,    tx_byte_s;
  logic           tx_valid_r,   tx_valid_s;
  logic           frame_done_r, frame_done_s;
  logic           busy_r,       busy_s;
  logic           accept_s;

  assign accept_s = tx_valid_r & tx_ready;

  // State and output registers; reset drops tx_valid immediately and abandons the frame.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= {TOT{1'b0}};
      nib_r        <= 3'd0;
      axis_r       <= 3'd0;
      tx_byte_r    <= 8'h00;
      tx_valid_r   <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      nib_r        <= nib_s;
      axis_r       <= axis_s;
      tx_byte_r    <= tx_byte_s;
      tx_valid_r   <= tx_valid_s;
      frame_done_r <= frame_done_s;
      busy_r       <= busy_s;
    end
  end

  // Next byte is computed on accept so consecutive bytes go out without a bubble.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    nib_s        = nib_r;
    axis_s       = axis_r;
    tx_byte_s    = tx_byte_r;
    tx_valid_s   = tx_valid_r;
    frame_done_s = 1'b0;
    busy_s       = busy_r;

    case (state_r)
      ST_IDLE: begin
        tx_valid_s = 1'b0;
        if (report_en) begin
          state_s = ST_SNAP;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end

      ST_SNAP: begin
        shift_s    = snapshot_s << 4;
        tx_byte_s  = hex2ascii(snapshot_s[TOT-1 -: 4]);
        tx_valid_s = 1'b1;
        nib_s      = 3'd0;
        axis_s     = 3'd0;
        state_s    = ST_HEX;
      end

      ST_HEX: begin
        if (accept_s) begin
          if (nib_r == LAST_NIB) begin
            if (axis_r < LAST_AXIS) begin
              tx_byte_s = SEP_CHAR;
              state_s   = ST_SEP;
            end else begin
              tx_byte_s = ASCII_LF;
              state_s   = ST_EOL;
            end
          end else begin
            nib_s     = nib_r + 3'd1;
            tx_byte_s = hex2ascii(shift_r[TOT-1 -: 4]);
            shift_s   = shift_r << 4;
          end
        end else begin
          state_s = ST_HEX;
        end
      end

      ST_SEP: begin
        if (accept_s) begin
          axis_s    = axis_r + 3'd1;
          nib_s     = 3'd0;
          tx_byte_s = hex2ascii(shift_r[TOT-1 -: 4]);
          shift_s   = shift_r << 4;
          state_s   = ST_HEX;
        end else begin
          state_s = ST_SEP;
        end
      end

      ST_EOL: begin
        if (accept_s) begin
          tx_valid_s   = 1'b0;
          frame_done_s = 1'b1;
          busy_s       = 1'b0;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_EOL;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  assign tx_byte    = tx_byte_r;
  assign tx_valid   = tx_valid_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_step_logger_hex.sv
// Self-checking bench for step_logger_hex: directed scenarios plus random step bursts,
// with frames predicted from a per-axis position array.
module tb_step_logger_hex;

  logic       hwclk     = 1'b0;
  logic       rst       = 1'b1;
  logic [3:0] step      = 4'h0;
  logic [3:0] dir       = 4'h0;
  logic       clear     = 1'b0;
  logic       report_en = 1'b0;
  logic       tx_ready  = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       frame_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_cnt [4];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];

  step_logger_hex #(.N_AXES(4), .NIBBLES(4), .SEP_CHAR(8'h2C)) dut (
    .hwclk      (hwclk),
    .rst        (rst),
    .step       (step),
    .dir        (dir),
    .clear      (clear),
    .report_en  (report_en),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int a = 0; a < 4; a++) model_cnt[a] = 16'h0000;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  // One step pulse on every axis in mask; dir set a cycle ahead and held.
  task automatic pulse(input logic [3:0] mask, input logic [3:0] dirs);
    @(negedge hwclk) dir = dirs;
    @(negedge hwclk) step = mask;
    @(negedge hwclk);
    @(negedge hwclk) step = 4'h0;
    @(negedge hwclk);
    for (int a = 0; a < 4; a++) begin
      if (mask[a]) model_cnt[a] = dirs[a] ? model_cnt[a] + 16'd1 : model_cnt[a] - 16'd1;
    end
  endtask

  task automatic build_exp();
    logic [3:0] nib;
    exp_q.delete();
    for (int a = 0; a < 4; a++) begin
      for (int n = 3; n >= 0; n--) begin
        nib = model_cnt[a][n*4 +: 4];
        exp_q.push_back((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib}));
      end
      exp_q.push_back((a < 3) ? 8'h2C : 8'h0A);
    end
  endtask

  // Requests one frame and collects it; stall_at/stall_len hold tx_ready low on one byte.
  task automatic run_frame(input int stall_at, input int stall_len, input bit rand_bp);
    int   stall_cnt = 0;
    bit   done = 1'b0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b1;
    logic [7:0] prev_b = 8'h00;
    got_q.delete();
    @(negedge hwclk) report_en = 1'b1;
    @(negedge hwclk) report_en = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) break;
      if (prev_v && !prev_r) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_byte", {24'd0, tx_byte}, {24'd0, prev_b});
      end
      check("no_early_done", {31'd0, frame_done}, 32'd0);
      if (got_q.size() == stall_at && stall_cnt < stall_len) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end else if (rand_bp) begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_byte);
        if (tx_byte == 8'h0A) done = 1'b1;
      end
      prev_v = tx_valid;
      prev_r = tx_ready;
      prev_b = tx_byte;
      @(negedge hwclk);
    end
    tx_ready = 1'b1;
    check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    check("busy_after_lf", {31'd0, busy}, 32'd0);
    @(negedge hwclk);
    check("frame_done_single", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic compare_frame(input string tag);
    logic [7:0] g;
    check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    bit seen_sep;
    model_zero();

    // Reset state
    settle(3);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    settle(2);

    // Three up-steps on axis0
    for (int p = 0; p < 3; p++) pulse(4'b0001, 4'b0001);
    settle(4);
    build_exp();
    run_frame(-1, 0, 1'b0);
    compare_frame("three_up");

    // Same counts, sink stalls for 5 cycles on the second byte
    run_frame(1, 5, 1'b0);
    compare_frame("stall");

    // Wrap below zero and back through all-F
    @(negedge hwclk) rst = 1'b1;
    model_zero();
    @(negedge hwclk) rst = 1'b0;
    pulse(4'b0110, 4'b0000);
    settle(4);
    build_exp();
    run_frame(-1, 0, 1'b0);
    compare_frame("wrap_down");
    pulse(4'b0100, 4'b0100);
    settle(4);
    build_exp();
    run_frame(-1, 0, 1'b0);
    compare_frame("wrap_up");

    // clear coinciding with axis3 edge reaching its counter
    for (int p = 0; p < 5; p++) pulse(4'b1000, 4'b1000);
    @(negedge hwclk) dir = 4'b1000;
    @(negedge hwclk) step = 4'b1000;
    @(negedge hwclk);
    @(negedge hwclk) step = 4'b0000;
    @(negedge hwclk) clear = 1'b1;
    @(negedge hwclk) clear = 1'b0;
    model_zero();
    settle(4);
    build_exp();
    run_frame(-1, 0, 1'b0);
    compare_frame("clear_prio");

    // Steps while the frame is being sent do not disturb it
    pulse(4'b0010, 4'b0010);
    settle(4);
    build_exp();
    fork
      run_frame(-1, 0, 1'b0);
      begin
        settle(4);
        for (int p = 0; p < 10; p++) pulse(4'b0001, 4'b0001);
      end
    join
    compare_frame("mid_frame");
    settle(4);
    build_exp();
    run_frame(-1, 0, 1'b0);
    compare_frame("after_mid");

    // Random step bursts with random backpressure
    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int p = 0; p < n; p++) pulse(4'($urandom), 4'($urandom));
      settle(4);
      build_exp();
      run_frame(-1, 0, 1'b1);
      compare_frame($sformatf("rand%0d", it));
    end

    // Reset while the separator is pending
    seen_sep = 1'b0;
    @(negedge hwclk) report_en = 1'b1;
    @(negedge hwclk) report_en = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (tx_valid && tx_byte == 8'h2C) begin
        seen_sep = 1'b1;
        break;
      end
      @(negedge hwclk);
    end
    check("sep_reached", {31'd0, seen_sep}, 32'd1);
    tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    model_zero();
    @(negedge hwclk) rst = 1'b0;
    tx_ready = 1'b1;
    settle(3);
    check("rst_mid_idle_valid", {31'd0, tx_valid}, 32'd0);
    build_exp();
    run_frame(-1, 0, 1'b0);
    compare_frame("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
